// File: rtl/nand_cpu_pkg.sv
// rtl/nand_cpu_pkg.sv - shared machine sizes, branch queue entry type and ROB age helper
// Purpose: ROB/register/PC sizing macros (overridable), derived widths, the
//          branch reservation-station entry layout and the ROB age function.
// Ports:   none (package)
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 16
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

package nand_cpu_pkg;

  localparam int BQ_ROB_AW = $clog2(`ROB_SIZE);
  localparam int BQ_D_AW   = $clog2(`NUM_D_REG);
  localparam int BQ_S_AW   = $clog2(`NUM_S_REG);
  localparam int BQ_PC_W   = `PC_SIZE;

  typedef struct packed {
    logic                 valid;
    logic [BQ_ROB_AW-1:0] rob_addr;
    logic                 jump;
    logic                 predict_taken;
    logic [BQ_PC_W-1:0]   pc;
    logic [BQ_PC_W-1:0]   predict_target;
    logic [BQ_D_AW-1:0]   rt_addr;
    logic [BQ_D_AW-1:0]   rw_addr;
    logic [BQ_S_AW-1:0]   rs_addr;
  } bq_entry_t;

  // Distance from the ROB head; wraps naturally because ROB_SIZE is a power of two.
  function automatic logic [BQ_ROB_AW-1:0] rob_age(input logic [BQ_ROB_AW-1:0] addr,
                                                   input logic [BQ_ROB_AW-1:0] head);
    return addr - head;
  endfunction

endpackage

// File: rtl/bq_oldest_select.sv
// rtl/bq_oldest_select.sv - combinational oldest-ready picker for the branch queue
// Purpose: among requesting entries pick the one with the smallest age.
// Ports:   req      - per-entry request (ready) vector
//          age_flat - per-entry ages, entry i at [i*ROB_AW +: ROB_AW]
//          grant    - one-hot grant of the winner
//          idx      - binary index of the winner
//          any      - at least one request present
module bq_oldest_select #(
  parameter int DEPTH  = 8,
  parameter int ROB_AW = 4
) (
  input  logic [DEPTH-1:0]        req,
  input  logic [DEPTH*ROB_AW-1:0] age_flat,
  output logic [DEPTH-1:0]        grant,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                    any
);

  localparam int IW = $clog2(DEPTH);

  logic [ROB_AW-1:0] best_age;

  // Strict less-than keeps the lowest index on equal ages.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req[i] && (!any || (age_flat[i*ROB_AW +: ROB_AW] < best_age))) begin
        any      = 1'b1;
        best_age = age_flat[i*ROB_AW +: ROB_AW];
        idx      = IW'(i);
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/branch_issue_queue.sv
// rtl/branch_issue_queue.sv - branch reservation station with oldest-ready issue and restore flush
// Purpose: holds up to DEPTH renamed branches, wakes them from the calculated
//          lists, issues the oldest ready entry by ROB age over a valid/ready
//          handshake and drops entries younger than a restored ROB tail.
// Ports:   clk, n_rst (sync active-low)
//          in_valid/in_ready + in_* fields      - dispatch enqueue
//          r_calculated_list, s_calculated_list - wakeup tag lists
//          rob_head                             - age reference
//          restore, restore_tail                - mispredict recovery flush
//          out_valid/out_ready + out_* fields   - issue to branch unit
//          count, full                          - occupancy
module branch_issue_queue
  import nand_cpu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ROB_AW = BQ_ROB_AW,
  parameter int D_AW   = BQ_D_AW,
  parameter int S_AW   = BQ_S_AW
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROB_AW-1:0]          in_rob_addr,
  input  logic                       in_jump,
  input  logic                       in_predict_taken,
  input  logic [`PC_SIZE-1:0]        in_pc,
  input  logic [`PC_SIZE-1:0]        in_predict_target,
  input  logic [D_AW-1:0]            in_rt_addr,
  input  logic [D_AW-1:0]            in_rw_addr,
  input  logic [S_AW-1:0]            in_rs_addr,
  input  logic [`NUM_D_REG-1:0]      r_calculated_list,
  input  logic [`NUM_S_REG-1:0]      s_calculated_list,
  input  logic [ROB_AW-1:0]          rob_head,
  input  logic                       restore,
  input  logic [ROB_AW-1:0]          restore_tail,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ROB_AW-1:0]          out_rob_addr,
  output logic                       out_jump,
  output logic                       out_predict_taken,
  output logic [`PC_SIZE-1:0]        out_pc,
  output logic [`PC_SIZE-1:0]        out_predict_target,
  output logic [D_AW-1:0]            out_rt_addr,
  output logic [D_AW-1:0]            out_rw_addr,
  output logic [S_AW-1:0]            out_rs_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  bq_entry_t               entries_q [DEPTH];
  bq_entry_t               entries_d [DEPTH];
  logic [CW-1:0]           count_q, count_d;

  logic [DEPTH-1:0]        ready;
  logic [DEPTH-1:0]        survive;
  logic [DEPTH-1:0]        grant;
  logic [DEPTH-1:0]        free_oh;
  logic [DEPTH*ROB_AW-1:0] age_flat;
  logic [IW-1:0]           sel_idx;
  logic                    sel_any;
  logic [ROB_AW-1:0]       keep_span;
  logic                    free_found;
  logic                    issue;
  logic                    accept;
  bq_entry_t               sel_e;
  bq_entry_t               new_e;

  // Entries with age below this span are older than the restored tail.
  assign keep_span = restore_tail - rob_head;

  always_comb begin
    ready    = '0;
    survive  = '0;
    age_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = entries_q[i].valid
               & r_calculated_list[entries_q[i].rt_addr]
               & (entries_q[i].jump | s_calculated_list[entries_q[i].rs_addr]);
      age_flat[i*ROB_AW +: ROB_AW] = rob_age(entries_q[i].rob_addr, rob_head);
      survive[i] = rob_age(entries_q[i].rob_addr, rob_head) < keep_span;
    end
  end

  bq_oldest_select #(
    .DEPTH (DEPTH),
    .ROB_AW(ROB_AW)
  ) u_select (
    .req     (ready),
    .age_flat(age_flat),
    .grant   (grant),
    .idx     (sel_idx),
    .any     (sel_any)
  );

  // Lowest-index free slot from pre-edge state, so it never aliases the issuing slot.
  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!entries_q[i].valid && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign in_ready  = ~full & ~restore;
  assign accept    = in_valid & in_ready;
  assign out_valid = sel_any & (~restore | survive[sel_idx]);
  assign issue     = out_valid & out_ready;

  always_comb begin
    sel_e = '0;
    if (sel_any) sel_e = entries_q[sel_idx];
  end

  assign out_rob_addr       = sel_e.rob_addr;
  assign out_jump           = sel_e.jump;
  assign out_predict_taken  = sel_e.predict_taken;
  assign out_pc             = sel_e.pc;
  assign out_predict_target = sel_e.predict_target;
  assign out_rt_addr        = sel_e.rt_addr;
  assign out_rw_addr        = sel_e.rw_addr;
  assign out_rs_addr        = sel_e.rs_addr;

  always_comb begin
    new_e                = '0;
    new_e.valid          = 1'b1;
    new_e.rob_addr       = in_rob_addr;
    new_e.jump           = in_jump;
    new_e.predict_taken  = in_predict_taken;
    new_e.pc             = in_pc;
    new_e.predict_target = in_predict_target;
    new_e.rt_addr        = in_rt_addr;
    new_e.rw_addr        = in_rw_addr;
    new_e.rs_addr        = in_rs_addr;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (issue && grant[i])      entries_d[i].valid = 1'b0;
      if (restore && !survive[i]) entries_d[i].valid = 1'b0;
      if (accept && free_oh[i])   entries_d[i] = new_e;
      count_d = count_d + CW'(entries_d[i].valid);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_branch_issue_queue.sv
// tb/tb_branch_issue_queue.sv - scoreboard bench for branch_issue_queue against a list-based model
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 16
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module tb_branch_issue_queue;

  localparam int DEPTH = 8;
  localparam int RAW   = $clog2(`ROB_SIZE);
  localparam int DAW   = $clog2(`NUM_D_REG);
  localparam int SAW   = $clog2(`NUM_S_REG);
  localparam int PCW   = `PC_SIZE;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int FW    = RAW + 2 + 2*PCW + 2*DAW + SAW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  n_rst;
  logic                  in_valid, in_ready, in_jump, in_predict_taken;
  logic [RAW-1:0]        in_rob_addr, rob_head, restore_tail, out_rob_addr;
  logic [PCW-1:0]        in_pc, in_predict_target, out_pc, out_predict_target;
  logic [DAW-1:0]        in_rt_addr, in_rw_addr, out_rt_addr, out_rw_addr;
  logic [SAW-1:0]        in_rs_addr, out_rs_addr;
  logic [`NUM_D_REG-1:0] r_calculated_list;
  logic [`NUM_S_REG-1:0] s_calculated_list;
  logic                  restore, out_valid, out_ready, out_jump, out_predict_taken, full;
  logic [CW-1:0]         count;

  branch_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rob_addr(in_rob_addr), .in_jump(in_jump),
    .in_predict_taken(in_predict_taken), .in_pc(in_pc), .in_predict_target(in_predict_target),
    .in_rt_addr(in_rt_addr), .in_rw_addr(in_rw_addr), .in_rs_addr(in_rs_addr),
    .r_calculated_list(r_calculated_list), .s_calculated_list(s_calculated_list),
    .rob_head(rob_head), .restore(restore), .restore_tail(restore_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_rob_addr(out_rob_addr),
    .out_jump(out_jump), .out_predict_taken(out_predict_taken), .out_pc(out_pc),
    .out_predict_target(out_predict_target), .out_rt_addr(out_rt_addr),
    .out_rw_addr(out_rw_addr), .out_rs_addr(out_rs_addr), .count(count), .full(full)
  );

  typedef struct {
    bit             nrst, iv, jump, pt, ordy, rest;
    bit [RAW-1:0]   rob, head, rtail;
    bit [PCW-1:0]   pc, tgt;
    bit [DAW-1:0]   rt, rw;
    bit [SAW-1:0]   rs;
    bit [`NUM_D_REG-1:0] rlist;
    bit [`NUM_S_REG-1:0] slist;
  } stim_t;

  typedef struct {
    bit [RAW-1:0] rob;
    bit           jump, pt;
    bit [PCW-1:0] pc, tgt;
    bit [DAW-1:0] rt, rw;
    bit [SAW-1:0] rs;
  } ment_t;

  typedef struct { int cyc; ment_t e; } iss_t;
  typedef struct { int cyc; int cnt; bit full; bit in_ready; } sts_t;

  stim_t s;
  ment_t mq[$];
  iss_t  iq[$];
  sts_t  sq[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  function automatic bit [FW-1:0] pack(input ment_t e);
    return {e.rob, e.jump, e.pt, e.pc, e.tgt, e.rt, e.rw, e.rs};
  endfunction

  function automatic bit [RAW-1:0] age(input bit [RAW-1:0] x, input bit [RAW-1:0] h);
    return x - h;
  endfunction

  function automatic bit in_model(input bit [RAW-1:0] r);
    foreach (mq[i]) if (mq[i].rob == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [RAW-1:0] pick_rob();
    bit [RAW-1:0] r;
    for (int t = 0; t < 32; t++) begin
      r = RAW'($urandom);
      if (!in_model(r)) return r;
    end
    for (int k = 0; k < `ROB_SIZE; k++) begin
      r = RAW'(k);
      if (!in_model(r)) return r;
    end
    return '0;
  endfunction

  // One clock of stimulus: drive, predict from the model, update the model.
  task automatic step();
    int    best;
    int    size0;
    bit    ev;
    bit [RAW-1:0] lim;
    ment_t keep[$];
    ment_t ne;
    iss_t  ir;
    sts_t  sr;
    @(posedge clk);
    #1;
    cyc++;
    n_rst = s.nrst; in_valid = s.iv; in_rob_addr = s.rob; in_jump = s.jump;
    in_predict_taken = s.pt; in_pc = s.pc; in_predict_target = s.tgt;
    in_rt_addr = s.rt; in_rw_addr = s.rw; in_rs_addr = s.rs;
    r_calculated_list = s.rlist; s_calculated_list = s.slist;
    rob_head = s.head; restore = s.rest; restore_tail = s.rtail; out_ready = s.ordy;

    best = -1;
    foreach (mq[i]) begin
      if (s.rlist[mq[i].rt] && (mq[i].jump || s.slist[mq[i].rs])) begin
        if (best < 0 || age(mq[i].rob, s.head) < age(mq[best].rob, s.head)) best = i;
      end
    end
    lim   = s.rtail - s.head;
    ev    = (best >= 0) && (!s.rest || (age(mq[best].rob, s.head) < lim));
    size0 = mq.size();
    sr.cyc = cyc; sr.cnt = size0; sr.full = (size0 == DEPTH);
    sr.in_ready = (size0 < DEPTH) && !s.rest;
    sq.push_back(sr);
    if (ev) begin
      ir.cyc = cyc; ir.e = mq[best];
      iq.push_back(ir);
    end

    if (!s.nrst) begin
      mq.delete();
    end else begin
      if (ev && s.ordy) mq.delete(best);
      if (s.rest) begin
        foreach (mq[i]) if (age(mq[i].rob, s.head) < lim) keep.push_back(mq[i]);
        mq = keep;
      end
      if (s.iv && size0 < DEPTH && !s.rest) begin
        ne.rob = s.rob; ne.jump = s.jump; ne.pt = s.pt; ne.pc = s.pc; ne.tgt = s.tgt;
        ne.rt = s.rt; ne.rw = s.rw; ne.rs = s.rs;
        mq.push_back(ne);
      end
    end
  endtask

  task automatic idle();
    s.nrst = 1'b1; s.iv = 1'b0; s.rest = 1'b0; s.ordy = 1'b1;
  endtask

  task automatic enq(input int rob, input bit jump, input int rt, input int rs);
    s.iv = 1'b1; s.rob = RAW'(rob); s.jump = jump; s.rt = DAW'(rt); s.rs = SAW'(rs);
    s.pt = 1'($urandom); s.pc = $urandom; s.tgt = $urandom; s.rw = DAW'($urandom);
  endtask

  // Monitor: occupancy every cycle, issue records whenever the DUT presents out_valid.
  initial begin
    iss_t e;
    forever begin
      @(negedge clk);
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        checks += 3;
        if (int'(count) != sq[0].cnt) begin
          errors++; $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, count, sq[0].cnt);
        end
        if (full !== sq[0].full) begin
          errors++; $display("FAIL full cyc=%0d got=%b exp=%b", cyc, full, sq[0].full);
        end
        if (in_ready !== sq[0].in_ready) begin
          errors++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, sq[0].in_ready);
        end
        void'(sq.pop_front());
      end
      while (iq.size() > 0 && iq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missed_out_valid cyc=%0d got=0 exp rob=%0d", iq[0].cyc, iq[0].e.rob);
        void'(iq.pop_front());
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (iq.size() == 0 || iq[0].cyc != cyc) begin
          errors++; $display("FAIL unexpected_out_valid cyc=%0d got rob=%0d exp none", cyc, out_rob_addr);
        end else begin
          e = iq.pop_front();
          if ({out_rob_addr, out_jump, out_predict_taken, out_pc, out_predict_target,
               out_rt_addr, out_rw_addr, out_rs_addr} !== pack(e.e)) begin
            errors++;
            $display("FAIL out_fields cyc=%0d got rob=%0d pc=%h exp rob=%0d pc=%h", cyc,
                     out_rob_addr, out_pc, e.e.rob, e.e.pc);
          end
        end
      end else if (out_valid !== 1'b0 && cyc > 0) begin
        checks++; errors++; $display("FAIL out_valid_x cyc=%0d got=%b exp=0/1", cyc, out_valid);
      end
    end
  end

  initial begin
    n_rst = 1'b0; in_valid = 1'b0; in_rob_addr = '0; in_jump = 1'b0; in_predict_taken = 1'b0;
    in_pc = '0; in_predict_target = '0; in_rt_addr = '0; in_rw_addr = '0; in_rs_addr = '0;
    r_calculated_list = '0; s_calculated_list = '0; rob_head = '0; restore = 1'b0;
    restore_tail = '0; out_ready = 1'b0;
    s = '{default: 0};

    // reset then idle
    s.nrst = 1'b0; step(); step();
    idle(); step(); step();

    // single jump, rt ready: issues the cycle after enqueue
    s.rlist = '1; s.slist = '1;
    enq(5, 1'b1, 3, 0); step();
    idle(); step(); step();

    // head=14: rob 15 (age 1) must beat rob 1 (age 3)
    s.head = 14; s.rlist = '0;
    enq(1, 1'b1, 4, 0); step();
    enq(15, 1'b1, 7, 0); step();
    idle(); s.rlist = '1; step(); step(); step();

    // fill to full, then issue one while in_valid is held
    s.head = 0; s.rlist = '0;
    for (int i = 0; i < DEPTH; i++) begin enq(i, 1'b1, i, 0); step(); end
    enq(8, 1'b1, 8, 0); s.rlist = '1; step();
    idle(); s.rlist = '0; step();
    s.rlist = '1;
    for (int i = 0; i < DEPTH; i++) step();

    // head=2, restore tail=5: rob 3,4 survive, ready rob 6 is flushed without issuing
    s.head = 2; s.rlist = '0;
    enq(3, 1'b1, 3, 0); step();
    enq(4, 1'b1, 4, 0); step();
    enq(6, 1'b1, 6, 0); step();
    enq(9, 1'b1, 9, 0); step();
    idle(); s.rest = 1'b1; s.rtail = 5; s.rlist = 32'h1 << 6; step();
    idle(); step(); step();
    s.rlist = '1; step(); step(); step();

    // back-pressure hold, then an older non-jump wakes on its rs tag and takes over
    s.head = 0; s.rlist = '1; s.slist = '0;
    enq(3, 1'b0, 1, 2); s.ordy = 1'b0; step();
    enq(7, 1'b1, 1, 0); s.ordy = 1'b0; step();
    idle(); s.ordy = 1'b0; step(); step(); step();
    s.slist = 16'h1 << 2; step();
    s.ordy = 1'b1; step(); step(); step();

    // randomized traffic with occasional restore, head moves and reset
    for (int n = 0; n < 1500; n++) begin
      idle();
      if ($urandom_range(0, 199) == 0) s.nrst = 1'b0;
      if ($urandom_range(0, 2) != 0) enq(int'(pick_rob()), 1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
      s.ordy  = ($urandom_range(0, 3) != 0);
      s.rest  = ($urandom_range(0, 11) == 0);
      s.rtail = RAW'($urandom);
      if ($urandom_range(0, 15) == 0) s.head = RAW'($urandom);
      s.rlist = $urandom | $urandom;
      s.slist = `NUM_S_REG'($urandom | $urandom);
      step();
    end

    idle(); s.rlist = '1; s.slist = '1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    @(negedge clk);
    #1;
    while (iq.size() > 0) begin
      checks++; errors++;
      $display("FAIL missed_out_valid_end cyc=%0d got=0 exp rob=%0d", iq[0].cyc, iq[0].e.rob);
      void'(iq.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
